pkt_store_forward_filter: RTL and testbench
===========================================

# pkt_store_forward_filter

Store-and-forward packet buffer placed directly downstream of the encoder/decoder stage. It accepts the 32-bit AXI4-Stream packet produced by the decoder together with its per-packet drop verdict. It holds each packet in on-chip RAM until its last beat arrives, then either commits it for output or discards it by rewinding the write pointer. Only whole, accepted packets ever appear on the master port; dropped, oversize and reset-truncated packets never produce a downstream beat.

## Interface
- DATA_WIDTH, 32, tdata width; tstrb width is DATA_WIDTH/8.
- ADDR_WIDTH, 9, log2 of buffer depth in beats (512).
- CNT_WIDTH, 16, width of the status counters.

- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH  input beat data.
- s_axis_tstrb  in  DATA_WIDTH/8  input byte strobes, stored verbatim.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_drop  in  1  drop verdict; sampled only on the tlast handshake.
- m_axis_tdata  out  DATA_WIDTH  output beat data.
- m_axis_tstrb  out  DATA_WIDTH/8  output strobes.
- m_axis_tlast  out  1  output last beat.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- pkt_count  out  CNT_WIDTH  committed packets, saturating.
- drop_count  out  CNT_WIDTH  discarded packets (verdict or oversize), saturating.
- oversize  out  1  sticky; set when any packet exceeds the buffer.

## Operation
- Storage: RAM of 2^ADDR_WIDTH entries, each holding {tlast, tstrb, tdata}.
- Pointers: wr_ptr, commit_ptr, rd_ptr, each ADDR_WIDTH+1 bits, wrapping modulo 2^(ADDR_WIDTH+1).
- full = (wr_ptr − rd_ptr) == 2^ADDR_WIDTH.
- Output data is available when rd_ptr != commit_ptr.
- Input FSM states:
  - ACCEPT (reset state):
    - s_axis_tready = !full.
    - Each handshake writes RAM[wr_ptr] and increments wr_ptr.
    - On the tlast handshake with drop=0: commit_ptr ← wr_ptr+1; pkt_count++.
    - On the tlast handshake with drop=1: wr_ptr ← commit_ptr; drop_count++.
    - If full and wr_ptr−commit_ptr == 2^ADDR_WIDTH, the current packet alone fills the buffer: wr_ptr ← commit_ptr, oversize ← 1, go to DISCARD.
    - If full and committed data is still pending, hold s_axis_tready low until a read frees space.
  - DISCARD:
    - s_axis_tready = 1; beats are consumed and not written.
    - On the tlast handshake: drop_count++, return to ACCEPT. The drop input is ignored.
- Single-beat packets (tlast on the first beat) are legal and follow the same rules.
- Counters saturate at 2^CNT_WIDTH−1 and do not wrap.
- Read side:
  - Synchronous RAM read feeds a 2-entry output FIFO (skid).
  - m_axis_tvalid = output FIFO not empty.
  - Must sustain 1 beat/cycle while m_axis_tready=1.
  - Output beats reproduce tdata/tstrb/tlast exactly, in order.
- Simultaneous events:
  - Read and write in the same cycle are legal.
  - A read in the cycle where full would block a write frees the slot for the next cycle, not the current one.
  - Commit and read in the same cycle: the read uses the old commit_ptr.
- Reset mid-operation:
  - All pointers, FSM, output FIFO, counters and oversize are cleared next edge.
  - A partially received or partially emitted packet is lost.
  - No output beat appears until a new packet commits.

## Timing
- Reset values:
  - s_axis_tready=0 while areset=1, and 1 on the first cycle after reset.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tstrb=0.
  - pkt_count=0, drop_count=0, oversize=0.
- Latency: tlast handshake in cycle N; commit_ptr updated at end of N; RAM read in N+1; m_axis_tvalid=1 with beat 0 in cycle N+2.
- Input side never stalls except on full; tready does not depend on m_axis_tready combinationally.
- m_axis_tdata/tstrb/tlast are held stable while tvalid=1 and tready=0 (AXI4-Stream rule).
- Once asserted, m_axis_tvalid is not deasserted without a handshake.

## Test plan
- One 12-beat packet (words 0x00000001..0x0000000C, strb 0xF, final strb 0x3), drop=0, m_axis_tready=1 → 12 identical output beats, tlast only on beat 12, first tvalid 2 cycles after the input tlast handshake, pkt_count=1.
- The same packet with drop=1 on tlast, followed by a 19-beat packet with drop=0 → only the 19 beats appear; drop_count=1, pkt_count=1.
- 600-beat packet with ADDR_WIDTH=9 and m_axis_tready=1 → no output, oversize=1, drop_count=1, tready stays high through tlast. A following 12-beat packet passes intact.
- m_axis_tready=0 while three 200-beat packets arrive → s_axis_tready drops during the third packet. After m_axis_tready=1, all 600 beats emerge in order with no loss.
- Random m_axis_tready (50%) with back-to-back 1-beat and 12-beat packets → tdata/tstrb/tlast held stable during stalls; the scoreboard matches every committed beat.
- areset pulsed for 1 cycle mid-way through the output of packet 2 of 3 → outputs and counters go to 0. No further beats appear until a freshly sent packet commits, and that packet is emitted intact.

Source files
------------

// File: rtl/pkt_store_forward_filter.sv
// -----------------------------------------------------------------------------
// pkt_store_forward_filter
//
// Store-and-forward packet buffer. Each incoming AXI4-Stream packet is written
// into on-chip RAM and only becomes visible to the read side once its last beat
// has arrived with a keep verdict (commit). Dropped packets, packets larger than
// the whole buffer, and packets cut short by reset are discarded by rewinding
// the write pointer, so they never produce a downstream beat.
//
// Ports
//   aclk, areset             clock, synchronous active-high reset
//   s_axis_t*                input stream (tdata/tstrb/tlast/tvalid/tready)
//   s_axis_drop              per-packet drop verdict, sampled with tlast
//   m_axis_t*                output stream of committed packets
//   pkt_count / drop_count   saturating committed / discarded packet counters
//   oversize                 sticky flag: a packet did not fit in the buffer
//
// Input FSM
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_ACCEPT  | storing beats of the current packet into RAM
//   ST_DISCARD | oversize packet: swallow remaining beats up to tlast
// -----------------------------------------------------------------------------
module pkt_store_forward_filter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_drop,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    drop_count,
    output logic                    oversize
);

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int RAM_DEPTH   = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ENTRY_WIDTH-1:0] ram [0:RAM_DEPTH-1];

    logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr;
    logic [ADDR_WIDTH:0] wr_ptr_nxt, commit_ptr_nxt;

    logic full, oversize_hit, in_ready;
    logic ram_we, pkt_inc, drop_inc, oversize_set;

    logic [ENTRY_WIDTH-1:0] ofifo [0:1];
    logic                   ofifo_wr_idx, ofifo_rd_idx;
    logic [1:0]             ofifo_cnt;
    logic                   rd_en, pop;

    // Extra pointer bit distinguishes full from empty.
    assign full = (wr_ptr - rd_ptr) == DEPTH;

    // Buffer is full and every stored beat belongs to the packet still being
    // received: nothing can ever be read out to make room, so the packet is
    // abandoned. The beat offered in this cycle is consumed and thrown away,
    // which keeps tready high through an oversize packet.
    assign oversize_hit = full && ((wr_ptr - commit_ptr) == DEPTH);

    assign s_axis_tready = in_ready;

    always_comb begin
        state_nxt      = state;
        in_ready       = 1'b0;
        ram_we         = 1'b0;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        pkt_inc        = 1'b0;
        drop_inc       = 1'b0;
        oversize_set   = 1'b0;
        if (!areset) begin
            unique case (state)
                ST_ACCEPT: begin
                    in_ready = !full || oversize_hit;
                    if (s_axis_tvalid && in_ready) begin
                        if (oversize_hit) begin
                            wr_ptr_nxt   = commit_ptr;
                            oversize_set = 1'b1;
                            if (s_axis_tlast) begin
                                drop_inc = 1'b1;
                            end else begin
                                state_nxt = ST_DISCARD;
                            end
                        end else begin
                            ram_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + PTR_ONE;
                            if (s_axis_tlast) begin
                                if (s_axis_drop) begin
                                    wr_ptr_nxt = commit_ptr;
                                    drop_inc   = 1'b1;
                                end else begin
                                    commit_ptr_nxt = wr_ptr + PTR_ONE;
                                    pkt_inc        = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DISCARD: begin
                    in_ready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        drop_inc  = 1'b1;
                        state_nxt = ST_ACCEPT;
                    end
                end
                default: state_nxt = ST_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ST_ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            oversize   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            if (pkt_inc && (pkt_count != {CNT_WIDTH{1'b1}})) begin
                pkt_count <= pkt_count + CNT_ONE;
            end
            if (drop_inc && (drop_count != {CNT_WIDTH{1'b1}})) begin
                drop_count <= drop_count + CNT_ONE;
            end
            if (oversize_set) begin
                oversize <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (ram_we) begin
            ram[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
        end
    end

    // Read side: the RAM read lands directly in the 2-entry output FIFO, so the
    // FIFO slot acts as the RAM output register. A read is issued whenever a
    // slot will be free at the end of this cycle, which sustains one beat per
    // cycle while the consumer is ready.
    assign m_axis_tvalid = (ofifo_cnt != 2'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign rd_en         = (rd_ptr != commit_ptr) && ((ofifo_cnt != 2'd2) || pop);

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_ptr       <= '0;
            ofifo_wr_idx <= 1'b0;
            ofifo_rd_idx <= 1'b0;
            ofifo_cnt    <= 2'd0;
            ofifo[0]     <= '0;
            ofifo[1]     <= '0;
        end else begin
            if (rd_en) begin
                ofifo[ofifo_wr_idx] <= ram[rd_ptr[ADDR_WIDTH-1:0]];
                ofifo_wr_idx        <= ~ofifo_wr_idx;
                rd_ptr              <= rd_ptr + PTR_ONE;
            end
            if (pop) begin
                ofifo_rd_idx <= ~ofifo_rd_idx;
            end
            unique case ({rd_en, pop})
                2'b10:   ofifo_cnt <= ofifo_cnt + 2'd1;
                2'b01:   ofifo_cnt <= ofifo_cnt - 2'd1;
                default: ofifo_cnt <= ofifo_cnt;
            endcase
        end
    end

    assign {m_axis_tlast, m_axis_tstrb, m_axis_tdata} = ofifo[ofifo_rd_idx];

endmodule

// File: tb/tb_pkt_store_forward_filter.sv
// -----------------------------------------------------------------------------
// Testbench for pkt_store_forward_filter. A driver sends directed packets and
// pushes the beats of every packet expected to survive into a scoreboard queue
// once its tlast is accepted; an independent monitor pops and compares on each
// output handshake and checks that stalled outputs stay stable.
// -----------------------------------------------------------------------------
module tb_pkt_store_forward_filter;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int CW = 16;
    localparam int SW = DW / 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [SW-1:0] s_axis_tstrb = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_drop = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] drop_count;
    logic          oversize;

    pkt_store_forward_filter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tstrb (s_axis_tstrb),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_drop  (s_axis_drop),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count),
        .oversize     (oversize)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW+SW:0] sb [$];
    int popped      = 0;
    bit stall_seen  = 1'b0;
    int stall_pkt   = -1;
    int stall_cycles = 0;
    bit rand_done   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: samples on the falling edge, half a cycle away from the
    // rising edge where the handshake takes effect.
    initial begin : monitor
        logic           hold_pending;
        logic [DW+SW:0] held, beat, exp;
        hold_pending = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            beat = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
            if (areset) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                    check("hold_beat", 64'(beat), 64'(held));
                end
                hold_pending = 1'b0;
                if (m_axis_tvalid) begin
                    if (m_axis_tready) begin
                        if (sb.size() == 0) begin
                            fail_now("unexpected_beat", $sformatf("got 0x%0h expected no beat", beat));
                        end else begin
                            exp = sb.pop_front();
                            check("beat", 64'(beat), 64'(exp));
                        end
                        popped++;
                    end else begin
                        hold_pending = 1'b1;
                        held = beat;
                    end
                end
            end
        end
    end

    // Caller is at posedge+1. Returns at posedge+1 of the cycle after tlast
    // was accepted. Non-last beats carry the inverse drop value to show the
    // verdict only matters on tlast.
    task automatic send_pkt(input int n, input logic [31:0] base, input logic drop,
                            input bit expect_out, input int pkt_id);
        logic [DW+SW:0] local_q [$];
        bit done;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 32'(i);
            s_axis_tstrb  = (i == n - 1) ? 4'h3 : 4'hF;
            s_axis_tlast  = (i == n - 1);
            s_axis_drop   = (i == n - 1) ? drop : ~drop;
            done = 1'b0;
            for (int t = 0; t < 4000 && !done; t++) begin
                @(negedge aclk);
                if (s_axis_tready) begin
                    done = 1'b1;
                end else begin
                    stall_cycles++;
                    if (!stall_seen) begin
                        stall_seen = 1'b1;
                        stall_pkt  = pkt_id;
                    end
                end
                @(posedge aclk);
                #1;
            end
            if (!done) begin
                fail_now("send_timeout", $sformatf("pkt %0d beat %0d never accepted", pkt_id, i));
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            local_q.push_back({s_axis_tlast, s_axis_tstrb, s_axis_tdata});
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_drop   = 1'b0;
        if (expect_out) begin
            foreach (local_q[j]) sb.push_back(local_q[j]);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && t < 20000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 20000) begin
            fail_now(name, $sformatf("drain timeout, %0d beats still expected", sb.size()));
        end
        repeat (5) @(negedge aclk);
    endtask

    task automatic sync();
        @(posedge aclk);
        #1;
    endtask

    // One-cycle reset pulse followed by reset-value checks.
    task automatic do_reset();
        sync();
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        sb.delete();
        @(negedge aclk);
        check("tready_in_reset", 64'(s_axis_tready), 64'd0);
        sync();
        areset = 1'b0;
        @(negedge aclk);
        check("rst_tready", 64'(s_axis_tready), 64'd1);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_tstrb", 64'(m_axis_tstrb), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_oversize", 64'(oversize), 64'd0);
        sync();
    endtask

    initial begin : main
        int t;

        // 12-beat packet, latency and content
        do_reset();
        m_axis_tready = 1'b1;
        send_pkt(12, 32'h0000_0001, 1'b0, 1'b1, 0);
        @(negedge aclk);
        check("latency_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
        @(negedge aclk);
        check("latency_n2_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("latency_first_beat", 64'({m_axis_tlast, m_axis_tstrb, m_axis_tdata}),
              64'({1'b0, 4'hF, 32'h0000_0001}));
        wait_drain("drain_single");
        check("single_pkt_count", 64'(pkt_count), 64'd1);
        check("single_drop_count", 64'(drop_count), 64'd0);

        // dropped packet followed by a kept 19-beat packet
        do_reset();
        m_axis_tready = 1'b1;
        send_pkt(12, 32'h0000_0001, 1'b1, 1'b0, 0);
        send_pkt(19, 32'h0000_0100, 1'b0, 1'b1, 1);
        wait_drain("drain_drop");
        check("drop_pkt_count", 64'(pkt_count), 64'd1);
        check("drop_drop_count", 64'(drop_count), 64'd1);
        check("drop_oversize", 64'(oversize), 64'd0);

        // oversize packet, then a normal packet
        do_reset();
        m_axis_tready = 1'b1;
        stall_cycles = 0;
        stall_seen   = 1'b0;
        send_pkt(600, 32'h0000_2000, 1'b0, 1'b0, 0);
        check("oversize_no_stall", 64'(stall_cycles), 64'd0);
        check("oversize_flag", 64'(oversize), 64'd1);
        check("oversize_drop_count", 64'(drop_count), 64'd1);
        check("oversize_pkt_count", 64'(pkt_count), 64'd0);
        send_pkt(12, 32'h0000_3000, 1'b0, 1'b1, 1);
        wait_drain("drain_oversize");
        check("after_oversize_pkt_count", 64'(pkt_count), 64'd1);
        check("oversize_sticky", 64'(oversize), 64'd1);

        // backpressure: three 200-beat packets with the consumer stalled
        do_reset();
        m_axis_tready = 1'b0;
        stall_cycles = 0;
        stall_seen   = 1'b0;
        stall_pkt    = -1;
        fork
            begin
                send_pkt(200, 32'h0001_0000, 1'b0, 1'b1, 0);
                send_pkt(200, 32'h0002_0000, 1'b0, 1'b1, 1);
                send_pkt(200, 32'h0003_0000, 1'b0, 1'b1, 2);
            end
            begin
                int w;
                w = 0;
                while (!stall_seen && w < 3000) begin
                    @(negedge aclk);
                    w++;
                end
                repeat (10) @(posedge aclk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        check("bp_stall_seen", 64'(stall_seen), 64'd1);
        check("bp_stall_pkt", 64'(stall_pkt), 64'd2);
        wait_drain("drain_backpressure");
        check("bp_pkt_count", 64'(pkt_count), 64'd3);

        // random consumer stalls with alternating 1-beat / 12-beat packets
        do_reset();
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send_pkt((k % 2 == 0) ? 1 : 12, 32'h4000_0000 + 32'(k * 256), 1'b0, 1'b1, k);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge aclk);
                    #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        sync();
        m_axis_tready = 1'b1;
        wait_drain("drain_random");
        check("rand_pkt_count", 64'(pkt_count), 64'd10);

        // reset in the middle of emitting packet 2 of 3
        do_reset();
        m_axis_tready = 1'b0;
        send_pkt(12, 32'h5000_0000, 1'b0, 1'b1, 0);
        send_pkt(12, 32'h5100_0000, 1'b0, 1'b1, 1);
        send_pkt(12, 32'h5200_0000, 1'b0, 1'b1, 2);
        popped = 0;
        m_axis_tready = 1'b1;
        t = 0;
        while (popped < 17 && t < 1000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 1000) fail_now("midreset_wait", "packet 2 output never started");
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            check("post_reset_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        end
        sync();
        send_pkt(12, 32'h6000_0000, 1'b0, 1'b1, 0);
        wait_drain("drain_after_reset");
        check("post_reset_pkt_count", 64'(pkt_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
